riscv_cpu: RTL and testbench

Single-cycle RV32I-subset processor core with a custom 8-bit dot-product/accumulate (MAC) instruction for small AI kernels. Instruction memory, data memory and register file are internal. The core is self-contained: only a clock and reset enter it, and a bench loads programs and checks results through hierarchical access.

---
 rtl/riscv_pkg.sv | 64 ++++++
 rtl/riscv_dmem.sv | 27 ++
 rtl/riscv_imem.sv | 25 ++
 rtl/riscv_mac8.sv | 20 ++
 rtl/riscv_regfile.sv | 31 +++
 rtl/riscv_cpu.sv | 199 +++++++++++++++++++
 tb/tb_riscv_cpu.sv | 150 +++++++++++++++
 7 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings, ALU operation and write-back selector types for the single-cycle RV32I core.
package riscv_pkg;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_MAC8 = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MAC8 = 7'b0010000;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALU, WB_MEM, WB_PC4, WB_MAC
   } wb_sel_e;

   // alt selects SUB/SRA; callers decide when bit 30 is meaningful
   function automatic alu_op_e alu_op_for(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_SLTU:    op = ALU_SLTU;
         F3_XOR:     op = ALU_XOR;
         F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      op = ALU_OR;
         F3_AND:     op = ALU_AND;
         default:    op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/riscv_dmem.sv
// Data memory: word-addressed, combinational read, write on the rising edge.
module riscv_dmem #(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [0:DEPTH-1];
   logic [AW-1:0] word_idx;

   // Byte offset bits are dropped, upper bits wrap
   assign word_idx = AW'(addr_i >> 2);

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[word_idx] <= wdata_i;
      end
   end

   assign rdata_o = mem[word_idx];

endmodule

// File: rtl/riscv_imem.sv
// Instruction memory: combinational word fetch, address wraps modulo a power-of-two depth.
module riscv_imem #(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        we_i,
   input  logic [31:0] waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] pc_i,
   output logic [31:0] instr_o
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0] mem [0:DEPTH-1];

   // Load port for an external loader; the core itself never writes here
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[AW'(waddr_i >> 2)] <= wdata_i;
      end
   end

   assign instr_o = mem[AW'(pc_i >> 2)];

endmodule

// File: rtl/riscv_mac8.sv
// Four-lane signed int8 dot product, purely combinational.
module riscv_mac8 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] dot_o
);
   logic signed [15:0] prod [0:3];
   logic        [31:0] prod_ext [0:3];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign prod[gi]     = $signed(a_i[8*gi +: 8]) * $signed(b_i[8*gi +: 8]);
         assign prod_ext[gi] = {{16{prod[gi][15]}}, prod[gi]};
      end
   endgenerate

   assign dot_o = prod_ext[0] + prod_ext[1] + prod_ext[2] + prod_ext[3];

endmodule

// File: rtl/riscv_regfile.sv
// 32x32 register file, three combinational read ports and one write port; x0 is never written.
module riscv_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  raddr_a_i,
   input  logic [4:0]  raddr_b_i,
   input  logic [4:0]  raddr_c_i,
   output logic [31:0] rdata_a_o,
   output logic [31:0] rdata_b_o,
   output logic [31:0] rdata_c_o,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i
);
   logic [31:0] regs [0:31];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (we_i && (waddr_i != 5'd0)) begin
         regs[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = regs[raddr_a_i];
   assign rdata_b_o = regs[raddr_b_i];
   assign rdata_c_o = regs[raddr_c_i];

endmodule

// File: rtl/riscv_cpu.sv
// Single-cycle RV32I-subset core with a custom int8 dot-product accumulate (MAC8) instruction.
module riscv_cpu
   import riscv_pkg::*;
#(
   parameter int IMEM_WORDS = 256,
   parameter int DMEM_WORDS = 256
) (
   input logic clk,
   input logic rst
);
   logic [31:0] pc_q, pc_d, pc_plus4;
   logic [31:0] instr;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_data, rs2_data, rd_data;
   logic [31:0] alu_a, alu_b, alu_res;
   logic [31:0] mem_addr, dmem_rdata, mac_dot, wb_data;
   logic        rf_we, dmem_we, br_taken;
   alu_op_e     alu_op;
   wb_sel_e     wb_sel;

   riscv_imem #(.DEPTH(IMEM_WORDS)) IMEM (
      .clk     (clk),
      .we_i    (1'b0),
      .waddr_i (32'd0),
      .wdata_i (32'd0),
      .pc_i    (pc_q),
      .instr_o (instr)
   );

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Third read port feeds the accumulator operand of MAC8
   riscv_regfile RF (
      .clk       (clk),
      .rst       (rst),
      .raddr_a_i (rs1),
      .raddr_b_i (rs2),
      .raddr_c_i (rd),
      .rdata_a_o (rs1_data),
      .rdata_b_o (rs2_data),
      .rdata_c_o (rd_data),
      .we_i      (rf_we && !rst),
      .waddr_i   (rd),
      .wdata_i   (wb_data)
   );

   riscv_mac8 MAC (
      .a_i   (rs1_data),
      .b_i   (rs2_data),
      .dot_o (mac_dot)
   );

   assign mem_addr = rs1_data + ((opcode == OPC_STORE) ? imm_s : imm_i);

   riscv_dmem #(.DEPTH(DMEM_WORDS)) DMEM (
      .clk     (clk),
      .we_i    (dmem_we && !rst),
      .addr_i  (mem_addr),
      .wdata_i (rs2_data),
      .rdata_o (dmem_rdata)
   );

   always_comb begin
      case (funct3)
         F3_BEQ:  br_taken = (rs1_data == rs2_data);
         F3_BNE:  br_taken = (rs1_data != rs2_data);
         F3_BLT:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
         F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
         F3_BLTU: br_taken = (rs1_data <  rs2_data);
         F3_BGEU: br_taken = (rs1_data >= rs2_data);
         default: br_taken = 1'b0;
      endcase
   end

   assign pc_plus4 = pc_q + 32'd4;

   // Anything not decoded below leaves rf_we/dmem_we low and falls through to pc+4
   always_comb begin
      rf_we   = 1'b0;
      dmem_we = 1'b0;
      wb_sel  = WB_ALU;
      alu_op  = ALU_ADD;
      alu_a   = rs1_data;
      alu_b   = imm_i;
      pc_d    = pc_plus4;
      case (opcode)
         OPC_LUI: begin
            rf_we = 1'b1;
            alu_a = '0;
            alu_b = imm_u;
         end
         OPC_AUIPC: begin
            rf_we = 1'b1;
            alu_a = pc_q;
            alu_b = imm_u;
         end
         OPC_JAL: begin
            rf_we  = 1'b1;
            wb_sel = WB_PC4;
            pc_d   = pc_q + imm_j;
         end
         OPC_JALR: begin
            if (funct3 == F3_ADD_SUB) begin
               rf_we  = 1'b1;
               wb_sel = WB_PC4;
               pc_d   = (rs1_data + imm_i) & ~32'd1;
            end
         end
         OPC_BRANCH: begin
            if (br_taken) begin
               pc_d = pc_q + imm_b;
            end
         end
         OPC_LOAD: begin
            if (funct3 == F3_WORD) begin
               rf_we  = 1'b1;
               wb_sel = WB_MEM;
            end
         end
         OPC_STORE: begin
            dmem_we = (funct3 == F3_WORD);
         end
         OPC_OP_IMM: begin
            // Bit 30 only selects SRAI; for other I-type ops it is immediate data
            alu_op = alu_op_for(funct3, (funct3 == F3_SRL_SRA) && (funct7 == F7_ALT));
            alu_b  = imm_i;
            if (funct3 == F3_SLL) begin
               rf_we = (funct7 == F7_BASE);
            end else if (funct3 == F3_SRL_SRA) begin
               rf_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            end else begin
               rf_we = 1'b1;
            end
         end
         OPC_OP: begin
            alu_op = alu_op_for(funct3, funct7 == F7_ALT);
            alu_b  = rs2_data;
            rf_we  = (funct7 == F7_BASE) ||
                     ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));
         end
         OPC_CUSTOM0: begin
            if ((funct3 == F3_MAC8) && (funct7 == F7_MAC8)) begin
               rf_we  = 1'b1;
               wb_sel = WB_MAC;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      case (alu_op)
         ALU_ADD:  alu_res = alu_a + alu_b;
         ALU_SUB:  alu_res = alu_a - alu_b;
         ALU_SLL:  alu_res = alu_a << alu_b[4:0];
         ALU_SLT:  alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU: alu_res = {31'b0, alu_a < alu_b};
         ALU_XOR:  alu_res = alu_a ^ alu_b;
         ALU_SRL:  alu_res = alu_a >> alu_b[4:0];
         ALU_SRA:  alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         ALU_OR:   alu_res = alu_a | alu_b;
         ALU_AND:  alu_res = alu_a & alu_b;
         default:  alu_res = alu_a + alu_b;
      endcase
   end

   always_comb begin
      case (wb_sel)
         WB_ALU:  wb_data = alu_res;
         WB_MEM:  wb_data = dmem_rdata;
         WB_PC4:  wb_data = pc_plus4;
         WB_MAC:  wb_data = rd_data + mac_dot;
         default: wb_data = alu_res;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: tb/tb_riscv_cpu.sv
// Directed-program bench for riscv_cpu: loads IMEM hierarchically, runs fixed cycle counts, checks RF/DMEM.
module tb_riscv_cpu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] prog_q [$];

   always #5 clk = ~clk;

   riscv_cpu #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
      .clk (clk),
      .rst (rst)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   // Clears both memories, loads prog_q, holds reset two edges, releases at a falling edge
   task automatic start_prog(input string name);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 256; i++) begin
         dut.IMEM.mem[i] = 32'd0;
         dut.DMEM.mem[i] = 32'd0;
      end
      foreach (prog_q[i]) dut.IMEM.mem[i] = prog_q[i];
      repeat (2) @(posedge clk);
      @(negedge clk);
      check({name, " pc in reset"}, dut.pc_q, 32'd0);
      rst = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] acc;

      // MAC kernel loop
      prog_q = '{32'h040300b7, 32'h20108093, 32'h08070137, 32'h60510113, 32'h00400193,
                 32'h2020850b, 32'hfff18193, 32'hfe019ce3, 32'h00a02023, 32'h0180066f};
      start_prog("mac");
      run(70);
      check("mac dmem0", dut.DMEM.mem[0], 32'd280);
      check("mac x3",    dut.RF.regs[3],  32'd0);
      check("mac x1",    dut.RF.regs[1],  32'h04030201);
      check("mac x2",    dut.RF.regs[2],  32'h08070605);
      check("mac x10",   dut.RF.regs[10], 32'd280);
      check("mac x12",   dut.RF.regs[12], 32'd40);

      // x0 protection
      prog_q = '{32'h00700293, 32'h00500013, 32'h000002b3};
      start_prog("x0");
      run(1);
      check("x0 c1 x0", dut.RF.regs[0], 32'd0);
      check("x0 c1 x5", dut.RF.regs[5], 32'd7);
      run(1);
      check("x0 c2 x0", dut.RF.regs[0], 32'd0);
      run(1);
      check("x0 c3 x0", dut.RF.regs[0], 32'd0);
      check("x0 c3 x5", dut.RF.regs[5], 32'd0);

      // Signed MAC: 10 + 4*(-1*2)
      prog_q = '{32'hfff00093, 32'h02020137, 32'h20210113, 32'h00a00513, 32'h2020850b};
      start_prog("smac");
      run(6);
      check("smac x2",  dut.RF.regs[2],  32'h02020202);
      check("smac x10", dut.RF.regs[10], 32'd2);

      // Branches with x1=-1, x2=1; taken branches skip the addi behind them
      prog_q = '{32'hfff00093, 32'h00100113,
                 32'h00209463, 32'h00100a13,   // bne  taken
                 32'h00208463, 32'h00100a93,   // beq  not taken
                 32'h0020c463, 32'h00100b13,   // blt  taken
                 32'h0020e463, 32'h00100b93,   // bltu not taken
                 32'h0020f463, 32'h00100c13,   // bgeu taken
                 32'h0020d463, 32'h00100c93};  // bge  not taken
      start_prog("br");
      run(20);
      check("br bne x20",  dut.RF.regs[20], 32'd0);
      check("br beq x21",  dut.RF.regs[21], 32'd1);
      check("br blt x22",  dut.RF.regs[22], 32'd0);
      check("br bltu x23", dut.RF.regs[23], 32'd1);
      check("br bgeu x24", dut.RF.regs[24], 32'd0);
      check("br bge x25",  dut.RF.regs[25], 32'd1);

      // SW then LW to the same address
      prog_q = '{32'hdeadc2b7, 32'heef28293, 32'h00502423, 32'h00802303};
      start_prog("ls");
      run(6);
      check("ls x5",    dut.RF.regs[5],  32'hdeadbeef);
      check("ls dmem2", dut.DMEM.mem[2], 32'hdeadbeef);
      check("ls x6",    dut.RF.regs[6],  32'hdeadbeef);

      // ALU ops, AUIPC, JALR, and an unsupported custom-0 funct7 acting as NOP
      prog_q = '{32'hff000093, 32'h00300113, 32'h402081b3, 32'h4020d233, 32'h0020d2b3,
                 32'h00209333, 32'h0020a3b3, 32'h0020b433, 32'h0ff0c493, 32'h4020d513,
                 32'h00001597, 32'h03c00667, 32'h00100693, 32'h00000000, 32'h00000000,
                 32'h00100713, 32'h0020e7b3, 32'h0024f833, 32'h0020878b};
      start_prog("alu");
      run(25);
      check("alu sub",   dut.RF.regs[3],  32'hffffffed);
      check("alu sra",   dut.RF.regs[4],  32'hfffffffe);
      check("alu srl",   dut.RF.regs[5],  32'h1ffffffe);
      check("alu sll",   dut.RF.regs[6],  32'hffffff80);
      check("alu slt",   dut.RF.regs[7],  32'd1);
      check("alu sltu",  dut.RF.regs[8],  32'd0);
      check("alu xori",  dut.RF.regs[9],  32'hffffff0f);
      check("alu srai",  dut.RF.regs[10], 32'hfffffffc);
      check("alu auipc", dut.RF.regs[11], 32'h00001028);
      check("alu jalr",  dut.RF.regs[12], 32'd48);
      check("alu skip",  dut.RF.regs[13], 32'd0);
      check("alu land",  dut.RF.regs[14], 32'd1);
      check("alu or/nop", dut.RF.regs[15], 32'hfffffff3);
      check("alu and",   dut.RF.regs[16], 32'd3);

      // Reset while the SW of the MAC kernel is executing
      prog_q = '{32'h040300b7, 32'h20108093, 32'h08070137, 32'h60510113, 32'h00400193,
                 32'h2020850b, 32'hfff18193, 32'hfe019ce3, 32'h00a02023, 32'h0180066f};
      start_prog("mrst");
      run(17);
      check("mrst pc at sw", dut.pc_q, 32'd32);
      check("mrst x10 pre",  dut.RF.regs[10], 32'd280);
      dut.DMEM.mem[0] = 32'h12345678;
      rst = 1'b1;
      run(1);
      check("mrst pc", dut.pc_q, 32'd0);
      acc = 32'd0;
      for (int i = 0; i < 32; i++) acc = acc | dut.RF.regs[i];
      check("mrst regs or", acc, 32'd0);
      check("mrst dmem0", dut.DMEM.mem[0], 32'h12345678);
      rst = 1'b0;
      run(1);
      check("mrst restart pc", dut.pc_q, 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
